adc_rx_framer: RTL and testbench
================================

# adc_rx_framer

Downstream consumer of the JESD receive block's user-clock output (`dout`, `dout_vld`, `dout_sync`).

- Aligns the continuous 512-bit ADC word stream to the converter SYSREF/sync marker.
- Cuts the stream into fixed-length frames, each carrying a sync-relative word timestamp.
- Buffers admitted frames whole in an internal FIFO so a backpressured consumer never receives a partial frame.
- Feeds the packetiser / DSP chain in the `user_clk` domain.

## Interface

Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- `DATA_W`, 512: sample word width; matches the JESD `dout` width.
- `FRAME_WORDS`, 64: words per frame. Range 2–FIFO_DEPTH.
- `FIFO_DEPTH`, 128: buffer entries. Power of 2, and at least FRAME_WORDS.
- `TS_W`, 64: timestamp width.

Ports:
- `user_clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `din` in DATA_W: sample word.
- `din_vld` in 1: word valid. No backpressure is available upstream.
- `din_sync` in 1: word carries the sync marker; qualified by `din_vld`.
- `enable` in 1: level; run request.
- `cnt_clr` in 1: pulse; clears the status counters.
- `dout` out DATA_W: frame word.
- `dout_vld` out 1: output valid.
- `dout_rdy` in 1: consumer ready.
- `dout_sof` out 1: first word of a frame.
- `dout_eof` out 1: last word of a frame.
- `dout_ts` out TS_W: frame timestamp, held constant for every word of the frame.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = RUN.
- `frame_drop_cnt` out 32: frames discarded for lack of space. Saturates.
- `sync_err_cnt` out 16: misaligned sync markers. Saturates.
- `fifo_count` out log2(FIFO_DEPTH)+1: current buffer occupancy.

## Operation

State machine:
- **IDLE**
  - All input is discarded.
  - Goes to ARMED when `enable`=1.
- **ARMED**
  - Words are discarded until a word with `din_vld`&`din_sync` arrives.
  - That word becomes frame word 0 with ts = 0, and the state goes to RUN.
  - `enable`=0 returns the block to IDLE.
- **RUN**
  - Each `din_vld` word advances `widx` (0..FRAME_WORDS-1, wrapping) and `ts` (+1 per word, wraps modulo 2^TS_W).
  - Frames are contiguous.

Frame admission:
- Evaluated at `widx`=0, using `fifo_count` sampled that cycle, before any same-cycle pop.
- The frame is admitted iff FIFO_DEPTH − fifo_count ≥ FRAME_WORDS.
- Admitted frame:
  - All FRAME_WORDS words are written.
  - Word 0 carries sof=1; word FRAME_WORDS-1 carries eof=1.
  - Every entry stores the frame-start ts.
  - The reservation guarantees no mid-frame overflow.
- Rejected frame:
  - All of its words are discarded.
  - `frame_drop_cnt` increments once.
  - Nothing is emitted.

Sync handling in RUN:
- `din_sync` on a word with `widx`≠0 increments `sync_err_cnt`.
- Alignment is not changed.
- `din_sync` at `widx`=0 is normal.

`enable` deasserted in RUN:
- If the current frame is admitted, it completes through eof, then the block goes to IDLE.
- Otherwise the block goes to IDLE immediately.
- `widx` and `ts` reset on the next ARMED→RUN entry.

FIFO entries:
- Each entry is {ts, eof, sof, din}.
- First-word-fall-through registered output.
- `dout*` hold stable while `dout_vld`&!`dout_rdy`.

`cnt_clr` zeroes `frame_drop_cnt` and `sync_err_cnt`. An increment in the same cycle is lost, because clear wins.

Reset (`rst`):
- State becomes IDLE and the FIFO is emptied.
- `widx`, `ts` and all counters are zeroed.
- `dout_vld`, `dout_sof`, `dout_eof` are 0.
- `dout` and `dout_ts` are 0.
- Reset mid-frame drops all buffered data; no eof is emitted.

## Timing

- Latency: a word with `din_vld` in cycle n appears on `dout` with `dout_vld`=1 in cycle n+2, given an empty FIFO and `dout_rdy`=1.
- Throughput: 1 word/cycle in and out.
- Simultaneous push and pop: both occur; `fifo_count` is unchanged.
- FIFO empty: `dout_vld`=0.
- Occupancy never exceeds FIFO_DEPTH, by construction of admission.
- `state` and the counters are registered and update the cycle after the causing input.

## Test plan

- **Basic framing.** After reset, `enable`=1. Stream 200 words with `din_vld`=1 and `din_sync` on word 5; `dout_rdy`=1.
  - Expect 3 frames of 64 words.
  - sof on input words 5, 69 and 133.
  - `dout_ts` = 0, 64, 128.
  - First `dout_vld` appears 2 cycles after word 5.
- **Backpressure / drop.** `dout_rdy`=0 with a continuous stream from sync.
  - Frames 0 and 1 are admitted (fifo_count = 128).
  - Frames 2 and 3 are dropped: `frame_drop_cnt`=2.
  - Then `dout_rdy`=1: exactly 128 words out, sof/eof intact, ts 0 and 64.
- **Sync misalignment.** A second `din_sync` at `widx`=10.
  - `sync_err_cnt`=1.
  - Frame boundaries are unchanged.
- **Disable mid-frame.** Drop `enable` at `widx`=30 of an admitted frame.
  - Words through `widx`=63 are emitted with eof.
  - `state`=IDLE the cycle after the eof word is written.
- **Reset mid-operation.** Assert `rst` with 40 words buffered.
  - Next cycle: `dout_vld`=0, fifo_count=0, `state`=0, counters 0.
- **Counter clear.** `cnt_clr` coincident with a frame drop.
  - `frame_drop_cnt` reads 0.
  - The next drop reads 1.

Source files
------------

// File: rtl/adc_rx_framer.sv
// Aligns the JESD word stream to the sync marker, cuts it into timestamped frames
// and buffers admitted frames whole in a first-word-fall-through FIFO.
module adc_rx_framer #(
    parameter int DATA_W      = 512,
    parameter int FRAME_WORDS = 64,
    parameter int FIFO_DEPTH  = 128,
    parameter int TS_W        = 64
) (
    input  logic                          user_clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_vld,
    input  logic                          din_sync,
    input  logic                          enable,
    input  logic                          cnt_clr,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_vld,
    input  logic                          dout_rdy,
    output logic                          dout_sof,
    output logic                          dout_eof,
    output logic [TS_W-1:0]               dout_ts,
    output logic [1:0]                    state,
    output logic [31:0]                   frame_drop_cnt,
    output logic [15:0]                   sync_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int WIDX_W  = $clog2(FRAME_WORDS);
    localparam int ENTRY_W = TS_W + 2 + DATA_W;

    localparam logic [AW:0]       DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       FRAME_C   = (AW+1)'(FRAME_WORDS);
    localparam logic [AW:0]       PTR_ONE   = 1;
    localparam logic [WIDX_W-1:0] WIDX_ONE  = 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(FRAME_WORDS - 1);
    localparam logic [TS_W-1:0]   TS_ONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WIDX_W-1:0]   widx_reg, widx_next;
    logic [TS_W-1:0]     ts_reg, ts_next;
    logic [TS_W-1:0]     frame_ts_reg, frame_ts_next;
    logic                admit_reg, admit_next;
    logic [AW:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]         count_reg, count_next;
    logic [31:0]         drop_cnt_reg;
    logic [15:0]         sync_err_reg;
    logic [DATA_W-1:0]   dout_reg;
    logic [TS_W-1:0]     dout_ts_reg;
    logic                dout_vld_reg, dout_sof_reg, dout_eof_reg;

    logic                push, push_sof, push_eof;
    logic [TS_W-1:0]     push_ts;
    logic                drop_inc, sync_inc;
    logic                admit_ok, widx_at_zero, widx_at_last;
    logic                pop, load, ram_nonempty;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];

    // Occupancy counts the output register too, so a frame is only admitted
    // when every one of its words already has a guaranteed slot.
    assign admit_ok     = (DEPTH_C - count_reg) >= FRAME_C;
    assign widx_at_zero = (widx_reg == '0);
    assign widx_at_last = (widx_reg == WIDX_LAST);

    always_comb begin
        state_next    = state_reg;
        widx_next     = widx_reg;
        ts_next       = ts_reg;
        frame_ts_next = frame_ts_reg;
        admit_next    = admit_reg;
        push          = 1'b0;
        push_sof      = 1'b0;
        push_eof      = 1'b0;
        push_ts       = frame_ts_reg;
        drop_inc      = 1'b0;
        sync_inc      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (enable) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (din_vld && din_sync) begin
                    state_next    = S_RUN;
                    widx_next     = WIDX_ONE;
                    ts_next       = TS_ONE;
                    frame_ts_next = '0;
                    admit_next    = admit_ok;
                    push          = admit_ok;
                    push_sof      = 1'b1;
                    push_ts       = '0;
                    drop_inc      = !admit_ok;
                end
            end
            S_RUN: begin
                // An admitted frame in flight is allowed to finish; anything else stops now.
                if (!enable && (widx_at_zero || !admit_reg)) begin
                    state_next = S_IDLE;
                end else if (din_vld) begin
                    ts_next   = ts_reg + TS_ONE;
                    widx_next = widx_at_last ? '0 : widx_reg + WIDX_ONE;
                    push_eof  = widx_at_last;
                    if (widx_at_zero) begin
                        frame_ts_next = ts_reg;
                        admit_next    = admit_ok;
                        push          = admit_ok;
                        push_sof      = 1'b1;
                        push_ts       = ts_reg;
                        drop_inc      = !admit_ok;
                    end else begin
                        push     = admit_reg;
                        sync_inc = din_sync;
                    end
                    if (widx_at_last && !enable) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            widx_reg     <= '0;
            ts_reg       <= '0;
            frame_ts_reg <= '0;
            admit_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            widx_reg     <= widx_next;
            ts_reg       <= ts_next;
            frame_ts_reg <= frame_ts_next;
            admit_reg    <= admit_next;
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
            sync_err_reg <= '0;
        end else if (cnt_clr) begin
            drop_cnt_reg <= '0;
            sync_err_reg <= '0;
        end else begin
            if (drop_inc && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 32'd1;
            if (sync_inc && (sync_err_reg != '1)) sync_err_reg <= sync_err_reg + 16'd1;
        end
    end

    assign ram_nonempty = (wr_ptr_reg != rd_ptr_reg);
    assign pop          = dout_vld_reg && dout_rdy;
    assign load         = ram_nonempty && (!dout_vld_reg || dout_rdy);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + PTR_ONE;
            2'b01:   count_next = count_reg - PTR_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= {push_ts, push_eof, push_sof, din};
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (load) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
        end
    end

    // Registered read doubles as the fall-through output stage.
    always_ff @(posedge user_clk) begin
        if (rst) begin
            {dout_ts_reg, dout_eof_reg, dout_sof_reg, dout_reg} <= '0;
            dout_vld_reg <= 1'b0;
        end else if (load) begin
            {dout_ts_reg, dout_eof_reg, dout_sof_reg, dout_reg} <= mem[rd_ptr_reg[AW-1:0]];
            dout_vld_reg <= 1'b1;
        end else if (dout_rdy) begin
            dout_vld_reg <= 1'b0;
        end
    end

    assign dout           = dout_reg;
    assign dout_vld       = dout_vld_reg;
    assign dout_sof       = dout_sof_reg;
    assign dout_eof       = dout_eof_reg;
    assign dout_ts        = dout_ts_reg;
    assign state          = state_reg;
    assign frame_drop_cnt = drop_cnt_reg;
    assign sync_err_cnt   = sync_err_reg;
    assign fifo_count     = count_reg;

endmodule

// File: tb/tb_adc_rx_framer.sv
// Scoreboard bench for adc_rx_framer: a frame-level reference model queues the
// expected words, a negedge monitor pops and compares every output handshake.
module tb_adc_rx_framer;

    localparam int DATA_W = 512;
    localparam int FW     = 64;
    localparam int DEPTH  = 128;
    localparam int TS_W   = 64;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              user_clk = 1'b0;
    logic              rst      = 1'b1;
    logic [DATA_W-1:0] din      = '0;
    logic              din_vld  = 1'b0;
    logic              din_sync = 1'b0;
    logic              enable   = 1'b0;
    logic              cnt_clr  = 1'b0;
    logic              dout_rdy = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_vld, dout_sof, dout_eof;
    logic [TS_W-1:0]   dout_ts;
    logic [1:0]        state;
    logic [31:0]       frame_drop_cnt;
    logic [15:0]       sync_err_cnt;
    logic [CW-1:0]     fifo_count;

    always #5 user_clk = ~user_clk;

    adc_rx_framer #(
        .DATA_W(DATA_W), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .user_clk(user_clk), .rst(rst), .din(din), .din_vld(din_vld),
        .din_sync(din_sync), .enable(enable), .cnt_clr(cnt_clr),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .dout_sof(dout_sof), .dout_eof(dout_eof), .dout_ts(dout_ts),
        .state(state), .frame_drop_cnt(frame_drop_cnt),
        .sync_err_cnt(sync_err_cnt), .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic              eof;
        logic              sof;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t            exp_q[$];
    int              m_q[$];      // cycle in which each buffered word was written
    int              n_chk = 0, n_err = 0, cyc = 0, rx_words = 0, rx_frames = 0;
    int              m_mode = 0;  // 0 idle, 1 armed, 2 run
    longint unsigned m_k = 0;     // words since the aligning sync word
    bit              m_adm = 1'b0;
    int unsigned     m_drop = 0, m_serr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock cycle: check registered outputs against the model, drive inputs,
    // then advance the model by the words the specification says this cycle carries.
    task automatic step(input bit en, input bit vld, input bit sync, input bit rdy,
                        input bit clr, input bit rs);
        logic [DATA_W-1:0] w;
        int   occ, nmode, pos;
        bit   pres, drop_ev, serr_ev, do_word;
        ent_t e;
        @(posedge user_clk);
        #1;
        pres = (m_q.size() > 0) && (m_q[0] + 2 <= cyc);
        chk("dout_vld", 64'(dout_vld), 64'(pres));
        chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        chk("state", 64'(state), 64'(m_mode));
        chk("frame_drop_cnt", 64'(frame_drop_cnt), 64'(m_drop));
        chk("sync_err_cnt", 64'(sync_err_cnt), 64'(m_serr));
        w        = rand_word();
        din      = w;
        din_vld  = vld;
        din_sync = sync;
        enable   = en;
        dout_rdy = rdy;
        cnt_clr  = clr;
        rst      = rs;
        if (rs) begin
            m_mode = 0; m_k = 0; m_adm = 1'b0; m_drop = 0; m_serr = 0;
            m_q.delete();
            exp_q.delete();
        end else begin
            occ = m_q.size();
            nmode = m_mode; drop_ev = 1'b0; serr_ev = 1'b0; do_word = 1'b0;
            if (pres && rdy) void'(m_q.pop_front());
            case (m_mode)
                0: if (en) nmode = 1;
                1: begin
                    if (!en) nmode = 0;
                    else if (vld && sync) begin m_k = 0; do_word = 1'b1; nmode = 2; end
                end
                default: begin
                    pos = int'(m_k % FW);
                    if (!en && (pos == 0 || !m_adm)) nmode = 0;
                    else if (vld) begin
                        do_word = 1'b1;
                        if (pos == FW - 1 && !en) nmode = 0;
                    end
                end
            endcase
            if (do_word) begin
                pos = int'(m_k % FW);
                if (pos == 0) begin
                    m_adm   = (DEPTH - occ) >= FW;
                    drop_ev = !m_adm;
                end else begin
                    serr_ev = sync;
                end
                if (m_adm) begin
                    e.ts  = TS_W'(m_k - longint'(pos));
                    e.eof = (pos == FW - 1);
                    e.sof = (pos == 0);
                    e.d   = w;
                    exp_q.push_back(e);
                    m_q.push_back(cyc);
                end
                m_k++;
            end
            m_mode = nmode;
            if (clr) begin
                m_drop = 0; m_serr = 0;
            end else begin
                if (drop_ev && m_drop != 32'hFFFF_FFFF) m_drop++;
                if (serr_ev && m_serr != 16'hFFFF) m_serr++;
            end
        end
        cyc++;
    endtask

    initial begin : monitor
        ent_t e, a;
        int fw_cnt = 0;
        forever begin
            @(negedge user_clk);
            if (dout_vld === 1'b1 && dout_rdy === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word cyc=%0d got ts=%0d sof=%0b eof=%0b exp none",
                             cyc, dout_ts, dout_sof, dout_eof);
                end else begin
                    e = exp_q.pop_front();
                    a = {dout_ts, dout_eof, dout_sof, dout};
                    rx_words++;
                    fw_cnt++;
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL frame_word cyc=%0d got ts=%0d sof=%0b eof=%0b d=%h exp ts=%0d sof=%0b eof=%0b d=%h",
                                 cyc, a.ts, a.sof, a.eof, a.d[63:0], e.ts, e.sof, e.eof, e.d[63:0]);
                    end
                    if (dout_eof) begin
                        rx_frames++;
                        $display("frame %0d ts=%0d words=%0d cyc=%0d", rx_frames, dout_ts, fw_cnt, cyc);
                        fw_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int  rx0;
        bit  dis, en, v, s, r, c;
        int  bias;
        repeat (3) @(posedge user_clk);

        // Reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_dout_zero", 64'(dout != '0), 64'(0));
        chk("rst_dout_ts", dout_ts, 64'(0));
        chk("rst_sof_eof", 64'({dout_sof, dout_eof}), 64'(0));

        // Basic framing: sync on word 5, consumer always ready, then disable mid-frame
        for (int i = 0; i < 200; i++) step(1, 1, i == 5, 1, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 1, 0, 1, 0, 0);

        // Backpressure: two frames fill the buffer, the next two are dropped
        for (int i = 0; i < 259; i++) step(1, 1, i == 3, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("bp_fifo_full", 64'(fifo_count), 64'(128));
        chk("bp_drop_cnt", 64'(frame_drop_cnt), 64'(2));
        rx0 = rx_words;
        for (int i = 0; i < 140; i++) step(0, 0, 0, 1, 0, 0);
        chk("bp_words_out", 64'(rx_words - rx0), 64'(128));

        // Misaligned second sync at widx 10, gappy input
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 150; i++) begin
            s = (i == 2) || (m_mode == 2 && m_k == 10);
            v = s || ($urandom_range(3) != 0);
            step(1, v, s, 1, 0, 0);
        end
        chk("sync_err_one", 64'(sync_err_cnt), 64'(1));

        // Disable at widx 30 of an admitted frame: finish through eof, then IDLE
        dis = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!dis && m_mode == 2 && (m_k % FW) == 30 && m_adm) dis = 1'b1;
            step(!dis, 1, 0, 1, 0, 0);
            if (dis && m_mode == 0) break;
        end
        step(0, 0, 0, 1, 0, 0);
        chk("disable_idle", 64'(state), 64'(0));
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);

        // Reset with 40 words buffered
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100 && m_q.size() < 40; i++) step(1, 1, i == 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rstmid_vld", 64'(dout_vld), 64'(0));
        chk("rstmid_count", 64'(fifo_count), 64'(0));
        chk("rstmid_state", 64'(state), 64'(0));
        chk("rstmid_drop", 64'(frame_drop_cnt), 64'(0));
        chk("rstmid_serr", 64'(sync_err_cnt), 64'(0));

        // Counter clear coincident with a drop
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 259; i++) begin
            c = (m_mode == 2 && m_k == 128);
            step(1, 1, i == 2, 0, c, 0);
            if (m_k == 130) chk("drop_after_clr", 64'(frame_drop_cnt), 64'(0));
            if (m_k == 194) chk("drop_after_next", 64'(frame_drop_cnt), 64'(1));
        end
        for (int i = 0; i < 300; i++) step(0, 0, 0, $urandom_range(1) == 1, 0, 0);

        // Randomised traffic with varying consumer throttling
        en = 1'b1;
        bias = 5;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) en = !en;
            if (i % 200 == 0) bias = $urandom_range(1, 9);
            v = $urandom_range(3) != 0;
            s = $urandom_range(39) == 0;
            r = $urandom_range(9) < bias;
            c = $urandom_range(299) == 0;
            step(en, v, s, r, c, 0);
        end
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 0, 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
